// File: rtl/instr_decode_seq.sv
// instr_decode_seq: multi-cycle fetch/decode/execute sequencer for the 9-bit CPU.
// Owns the program counter, fetches 9-bit instructions (opcode [8:4], operand [3:0])
// and issues one-cycle control strobes to the register file, ALU, data memory
// and function unit. Halts on "func 1111" (done) or reserved opcode 11000 (illegal).
module instr_decode_seq #(
  parameter int PW = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic [PW-1:0] instr_addr,
  output logic          instr_req,
  input  logic          instr_valid,
  input  logic [8:0]    instr_data,
  output logic [3:0]    rf_raddr,
  input  logic [8:0]    rf_rdata,
  output logic          rf_we,
  output logic [3:0]    rf_waddr,
  output logic [1:0]    imm_we,
  output logic          alu_go,
  output logic [3:0]    alu_op,
  input  logic          zf,
  output logic          sel_we,
  output logic          mem_re,
  output logic          mem_we,
  input  logic          mem_ready,
  output logic          func_go,
  output logic [3:0]    func_id,
  input  logic          func_ack,
  output logic          done,
  output logic          illegal
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM_WAIT, S_FUNC_WAIT, S_HALT
  } state_t;

  localparam logic [4:0] OP_LOAD = 5'b10000;
  localparam logic [4:0] OP_STOR = 5'b10001;
  localparam logic [4:0] OP_INCR = 5'b10010;
  localparam logic [4:0] OP_DECR = 5'b10011;
  localparam logic [4:0] OP_JIZR = 5'b10100;
  localparam logic [4:0] OP_JNZR = 5'b10101;
  localparam logic [4:0] OP_BIZR = 5'b10110;
  localparam logic [4:0] OP_BNZR = 5'b10111;
  localparam logic [4:0] OP_RSVD = 5'b11000;
  localparam logic [4:0] OP_SETH = 5'b11001;
  localparam logic [4:0] OP_MTHR = 5'b11010;
  localparam logic [4:0] OP_MTHS = 5'b11011;
  localparam logic [4:0] OP_LSLC = 5'b11100;
  localparam logic [4:0] OP_LSRC = 5'b11101;
  localparam logic [4:0] OP_FLIP = 5'b11110;
  localparam logic [4:0] OP_FUNC = 5'b11111;

  state_t        state_q, state_d;
  logic [PW-1:0] pc_q, pc_d;
  logic [8:0]    ir_q, ir_d;
  logic          done_q, done_d;
  logic          illegal_q, illegal_d;

  logic [4:0]    opcode;
  logic [3:0]    operand;
  logic [PW-1:0] pc_inc, pc_rel, pc_abs;
  logic          cond_taken;
  logic          in_exec, in_mem_wait;

  assign opcode      = ir_q[8:4];
  assign operand     = ir_q[3:0];
  assign pc_inc      = pc_q + PW'(1);
  // Relative branch: 4-bit two's complement offset, wraps modulo 2^PW.
  assign pc_rel      = pc_q + {{(PW-4){operand[3]}}, operand};
  assign pc_abs      = PW'(rf_rdata);
  // Opcode bit 0 selects the "not zero" flavour of jumps and branches.
  assign cond_taken  = opcode[0] ? ~zf : zf;
  assign in_exec     = (state_q == S_EXEC);
  assign in_mem_wait = (state_q == S_MEM_WAIT);

  assign instr_addr  = pc_q;
  assign instr_req   = (state_q == S_FETCH);
  assign done        = done_q;
  assign illegal     = illegal_q;

  // State, PC, latched instruction and halt flags; reset aborts any instruction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      ir_q      <= '0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state, PC update and instruction latch.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    done_d    = done_q;
    illegal_d = illegal_q;
    case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          state_d   = S_FETCH;
          pc_d      = '0;
          done_d    = 1'b0;
          illegal_d = 1'b0;
        end
      end
      S_FETCH: begin
        if (instr_valid) begin
          ir_d    = instr_data;
          state_d = S_DECODE;
        end
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        state_d = S_FETCH;
        pc_d    = pc_inc;
        case (opcode)
          OP_LOAD, OP_STOR: begin
            state_d = S_MEM_WAIT;
            pc_d    = pc_q;
          end
          OP_JIZR, OP_JNZR: if (cond_taken) pc_d = pc_abs;
          OP_BIZR, OP_BNZR: if (cond_taken) pc_d = pc_rel;
          OP_RSVD: begin
            state_d   = S_HALT;
            pc_d      = pc_q;
            illegal_d = 1'b1;
          end
          OP_FUNC: begin
            pc_d = pc_q;
            if (operand == 4'hF) begin
              state_d = S_HALT;
              done_d  = 1'b1;
            end else begin
              state_d = S_FUNC_WAIT;
            end
          end
          default: ;
        endcase
      end
      S_MEM_WAIT: begin
        if (mem_ready) begin
          pc_d    = pc_inc;
          state_d = S_FETCH;
        end
      end
      S_FUNC_WAIT: begin
        if (func_ack) begin
          pc_d    = pc_inc;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control decode: register indices/op codes from the latched instruction,
  // strobes qualified by EXEC (memory strobes also held through MEM_WAIT).
  always_comb begin
    rf_raddr = 4'h0;
    rf_we    = 1'b0;
    rf_waddr = 4'h0;
    imm_we   = 2'b00;
    alu_go   = 1'b0;
    alu_op   = 4'h0;
    sel_we   = 1'b0;
    mem_re   = 1'b0;
    mem_we   = 1'b0;
    func_go  = 1'b0;
    func_id  = 4'h0;
    if (!opcode[4]) begin
      if (opcode[3:1] == 3'b000) begin
        if (in_exec) imm_we = opcode[0] ? 2'b10 : 2'b01;
      end else begin
        // Register moves: destination is the low opcode nibble.
        rf_raddr = operand;
        rf_waddr = opcode[3:0];
        rf_we    = in_exec;
      end
    end else begin
      case (opcode)
        OP_LOAD: mem_re = in_exec | in_mem_wait;
        OP_STOR: mem_we = in_exec | in_mem_wait;
        OP_INCR, OP_DECR, OP_LSLC, OP_LSRC, OP_FLIP: begin
          rf_raddr = operand;
          rf_waddr = operand;
          rf_we    = in_exec;
          alu_go   = in_exec;
          case (opcode)
            OP_INCR: alu_op = 4'b1000;
            OP_DECR: alu_op = 4'b1001;
            OP_LSLC: alu_op = 4'b0101;
            OP_LSRC: alu_op = 4'b0100;
            default: alu_op = 4'b0010;
          endcase
        end
        OP_JIZR, OP_JNZR: rf_raddr = operand;
        OP_SETH: sel_we = in_exec;
        OP_MTHR, OP_MTHS: begin
          alu_go   = in_exec;
          alu_op   = operand;
          rf_we    = in_exec;
          rf_waddr = {3'b000, opcode[0]};
        end
        OP_FUNC: begin
          func_id = operand;
          func_go = in_exec & (operand != 4'hF);
        end
        default: ;
      endcase
    end
  end

endmodule
